// File: rtl/aes_pkg.sv
// aes_pkg: shared constants, byte-level helpers and FSM state type for the AES inverse round engine.
package aes_pkg;

    localparam int NR_MAX = 14;

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    // Byte k of the state sits at [127-8k -: 8]; row r of column c is byte 4c+r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127 - 8*(4*c + w) -: 8] = s[127 - 8*(4*((c - w + 4) % 4) + w) -: 8];
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_round_engine_if.sv
// aes_inv_round_engine_if: ciphertext/plaintext handshakes and key-store port of the inverse round engine.
interface aes_inv_round_engine_if;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] ciphertext, round_key, plaintext;
    logic [3:0]   rk_idx;
    modport master (output in_valid, ciphertext, round_key, out_ready,
                    input  in_ready, rk_idx, out_valid, plaintext, busy);
    modport slave  (input  in_valid, ciphertext, round_key, out_ready,
                    output in_ready, rk_idx, out_valid, plaintext, busy);
endinterface

// File: rtl/inv_mix_columns.sv
// inv_mix_columns: InvMixColumns over the four columns of a 128-bit AES state.
module inv_mix_columns (
    input  logic [127:0] state,
    output logic [127:0] result_state
);
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] a2, a4, a8;
        a2 = xt(a);
        a4 = xt(a2);
        a8 = xt(a4);
        return (k[0] ? a : 8'h00) ^ (k[1] ? a2 : 8'h00) ^ (k[2] ? a4 : 8'h00) ^ (k[3] ? a8 : 8'h00);
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        assign {w_a0, w_a1, w_a2, w_a3} = state[127 - 32*c -: 32];
        assign result_state[127 - 32*c -: 32] = {
            gm(w_a0, 4'he) ^ gm(w_a1, 4'hb) ^ gm(w_a2, 4'hd) ^ gm(w_a3, 4'h9),
            gm(w_a0, 4'h9) ^ gm(w_a1, 4'he) ^ gm(w_a2, 4'hb) ^ gm(w_a3, 4'hd),
            gm(w_a0, 4'hd) ^ gm(w_a1, 4'h9) ^ gm(w_a2, 4'he) ^ gm(w_a3, 4'hb),
            gm(w_a0, 4'hb) ^ gm(w_a1, 4'hd) ^ gm(w_a2, 4'h9) ^ gm(w_a3, 4'he)
        };
    end
endmodule

// File: rtl/inv_sub_bytes.sv
// inv_sub_bytes: sixteen parallel inverse S-box lookups across a 128-bit state.
module inv_sub_bytes
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    output logic [127:0] o_state
);
    for (genvar i = 0; i < 16; i++) begin : g_sb
        assign o_state[8*i +: 8] = inv_sbox(i_state[8*i +: 8]);
    end
endmodule

// File: rtl/aes_inv_round_engine.sv
// aes_inv_round_engine: iterative AES inverse cipher, one decryption round per clock,
// with round keys fetched from an external store addressed by rk_idx.
module aes_inv_round_engine
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input logic                   clk,
    input logic                   rst,
    aes_inv_round_engine_if.slave bus
);
    localparam logic [3:0] NR_IDX = 4'(NR);

    state_t       r_state, w_nxt_state;
    logic [3:0]   r_cnt, w_nxt_cnt;
    logic [127:0] r_state_reg, r_plaintext, w_isr, w_sub, w_ark, w_imc;
    logic         w_accept;

    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_isr    = inv_shift_rows(r_state_reg);
    assign w_ark    = w_sub ^ bus.round_key;

    inv_sub_bytes   u_isb (.i_state(w_isr), .o_state(w_sub));
    inv_mix_columns u_imc (.state(w_ark), .result_state(w_imc));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_reg <= '0;
            r_plaintext <= '0;
        end else begin
            if (w_accept) r_state_reg <= bus.ciphertext ^ bus.round_key;
            else if (r_state == ROUND) r_state_reg <= w_imc;
            if (r_state == FINAL) r_plaintext <= w_ark;
        end
    end

    // The counter doubles as rk_idx; in IDLE it is reloaded to NR before any block is keyed.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        case (r_state)
            IDLE: begin
                w_nxt_state = w_accept ? ROUND : IDLE;
                w_nxt_cnt   = w_accept ? NR_IDX - 4'd1 : NR_IDX;
            end
            ROUND: begin
                w_nxt_state = (r_cnt == 4'd1) ? FINAL : ROUND;
                w_nxt_cnt   = r_cnt - 4'd1;
            end
            FINAL: w_nxt_state = DONE;
            DONE: begin
                w_nxt_state = bus.out_ready ? IDLE : DONE;
                w_nxt_cnt   = bus.out_ready ? NR_IDX : r_cnt;
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == IDLE) && (r_cnt == NR_IDX);
        bus.busy      = r_state != IDLE;
        bus.out_valid = r_state == DONE;
        bus.rk_idx    = r_cnt;
        bus.plaintext = r_plaintext;
    end
endmodule

// File: tb/tb_aes_inv_round_engine.sv
// tb_aes_inv_round_engine: FIPS-197 known answers plus randomized blocks checked against
// a byte-array inverse-cipher model whose S-box is derived from GF(2^8) arithmetic.
module tb_aes_inv_round_engine;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];
    logic [127:0] ks10 [0:10];
    logic [127:0] ks14 [0:14];

    always #5 clk = ~clk;

    aes_inv_round_engine_if b10 ();
    aes_inv_round_engine_if b14 ();
    assign b10.round_key = (b10.rk_idx <= 4'd10) ? ks10[b10.rk_idx] : 128'h0;
    assign b14.round_key = (b14.rk_idx <= 4'd14) ? ks14[b14.rk_idx] : 128'h0;

    aes_inv_round_engine #(.NR(10)) u_dut10 (.clk(clk), .rst(rst), .bus(b10));
    aes_inv_round_engine #(.NR(14)) u_dut14 (.clk(clk), .rst(rst), .bus(b14));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            isb[sb[x]] = 8'(x);
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) w[i] = key[255 - 32*i -: 32];
            else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk > 6 && i % nk == 4) t = subw(t);
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= nr; r++)
            if (nk == 4) ks10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else ks14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rkey(input int nr, input int r);
        return (nr == 10) ? ks10[r] : ks14[r];
    endfunction

    function automatic logic [127:0] ref_dec(input logic [127:0] ct, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] k, res;
        k = rkey(nr, nr);
        for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int r = nr - 1; r >= 0; r--) begin
            k = rkey(nr, r);
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    t[4*c+w] = isb[s[4*((c - w + 4) % 4) + w]] ^ k[127 - 8*(4*c+w) -: 8];
            for (int c = 0; c < 4; c++) begin
                if (r > 0) begin
                    s[4*c]   = gmul(t[4*c], 8'h0e) ^ gmul(t[4*c+1], 8'h0b) ^ gmul(t[4*c+2], 8'h0d) ^ gmul(t[4*c+3], 8'h09);
                    s[4*c+1] = gmul(t[4*c], 8'h09) ^ gmul(t[4*c+1], 8'h0e) ^ gmul(t[4*c+2], 8'h0b) ^ gmul(t[4*c+3], 8'h0d);
                    s[4*c+2] = gmul(t[4*c], 8'h0d) ^ gmul(t[4*c+1], 8'h09) ^ gmul(t[4*c+2], 8'h0e) ^ gmul(t[4*c+3], 8'h0b);
                    s[4*c+3] = gmul(t[4*c], 8'h0b) ^ gmul(t[4*c+1], 8'h0d) ^ gmul(t[4*c+2], 8'h09) ^ gmul(t[4*c+3], 8'h0e);
                end else
                    for (int w = 0; w < 4; w++) s[4*c+w] = t[4*c+w];
            end
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic run10(input logic [127:0] ct, output logic [127:0] pt, output int lat, output bit to);
        int n;
        n = 0;
        b10.ciphertext = ct;
        b10.in_valid   = 1'b1;
        while (!b10.in_ready && n < 40) begin @(posedge clk); #1; n++; end
        to = !b10.in_ready;
        @(posedge clk); #1;
        b10.in_valid   = 1'b0;
        b10.ciphertext = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        while (!b10.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        to = to || !b10.out_valid;
        pt = b10.plaintext;
    endtask

    task automatic test_reset();
        b10.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (b10.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", b10.out_valid); end
        n_vec++; if (b10.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", b10.busy); end
        n_vec++; if (b10.plaintext !== 128'h0) begin n_err++; $display("FAIL reset_plaintext got %h want 0", b10.plaintext); end
        n_vec++; if (b10.rk_idx !== 4'd0) begin n_err++; $display("FAIL reset_rk_idx got %0d want 0", b10.rk_idx); end
        n_vec++; if (b14.rk_idx !== 4'd0) begin n_err++; $display("FAIL reset_rk_idx14 got %0d want 0", b14.rk_idx); end
        rst = 1'b0;
        b10.in_valid = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (b10.in_ready !== 1'b1 || b10.busy !== 1'b0) begin n_err++; $display("FAIL idle_ready got ready=%b busy=%b want 1/0", b10.in_ready, b10.busy); end
        n_vec++; if (b10.rk_idx !== 4'd10) begin n_err++; $display("FAIL idle_rk_idx got %0d want 10", b10.rk_idx); end
        n_vec++; if (b14.rk_idx !== 4'd14) begin n_err++; $display("FAIL idle_rk_idx14 got %0d want 14", b14.rk_idx); end
    endtask

    task automatic test_fips_b();
        logic [127:0] pt;
        int lat;
        bit to;
        expand({KEY_B, 128'h0}, 4);
        b10.out_ready = 1'b1;
        run10(CT_B, pt, lat, to);
        n_vec++; if (to) begin n_err++; $display("FAIL fips_b_timeout got timeout want completion"); end
        n_vec++; if (pt !== PT_B) begin n_err++; $display("FAIL fips_b_plaintext got %h want %h", pt, PT_B); end
        n_vec++; if (lat != 10) begin n_err++; $display("FAIL fips_b_latency got %0d want 10", lat); end
        @(posedge clk); #1;
        n_vec++; if (b10.out_valid !== 1'b0 || b10.in_ready !== 1'b1) begin n_err++; $display("FAIL fips_b_handshake got ov=%b rdy=%b want 0/1", b10.out_valid, b10.in_ready); end
    endtask

    task automatic test_fips_c1();
        int n;
        expand({KEY_C1, 128'h0}, 4);
        b10.ciphertext = CT_C1;
        b10.in_valid   = 1'b1;
        n = 0;
        while (!b10.in_ready && n < 40) begin @(posedge clk); #1; n++; end
        n_vec++; if (b10.rk_idx !== 4'd10) begin n_err++; $display("FAIL c1_rk_idx got %0d want 10", b10.rk_idx); end
        @(posedge clk); #1;
        b10.in_valid   = 1'b0;
        b10.ciphertext = 128'h0;
        for (int k = 9; k >= 0; k--) begin
            n_vec++; if (b10.rk_idx !== 4'(k)) begin n_err++; $display("FAIL c1_rk_idx got %0d want %0d", b10.rk_idx, k); end
            @(posedge clk); #1;
        end
        n_vec++; if (b10.out_valid !== 1'b1 || b10.plaintext !== PT_C) begin n_err++; $display("FAIL c1_plaintext got ov=%b %h want 1 %h", b10.out_valid, b10.plaintext, PT_C); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [127:0] pt;
        int lat;
        bit to;
        expand({KEY_B, 128'h0}, 4);
        b10.out_ready = 1'b0;
        run10(CT_B, pt, lat, to);
        n_vec++; if (to || pt !== PT_B) begin n_err++; $display("FAIL bp_plaintext got to=%b %h want 0 %h", to, pt, PT_B); end
        b10.ciphertext = CT_C1;
        b10.in_valid   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (b10.out_valid !== 1'b1 || b10.plaintext !== PT_B || b10.in_ready !== 1'b0 || b10.busy !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold cycle %0d got ov=%b rdy=%b busy=%b pt=%h want 1/0/1 %h", i, b10.out_valid, b10.in_ready, b10.busy, b10.plaintext, PT_B);
            end
        end
        b10.in_valid  = 1'b0;
        b10.out_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (b10.out_valid !== 1'b0 || b10.in_ready !== 1'b1 || b10.busy !== 1'b0) begin n_err++; $display("FAIL bp_release got ov=%b rdy=%b busy=%b want 0/1/0", b10.out_valid, b10.in_ready, b10.busy); end
        @(posedge clk); #1;
        n_vec++; if (b10.busy !== 1'b0) begin n_err++; $display("FAIL bp_no_accept got busy=%b want 0", b10.busy); end
    endtask

    task automatic test_back_to_back();
        int n, lat;
        expand({KEY_B, 128'h0}, 4);
        b10.out_ready  = 1'b1;
        b10.ciphertext = CT_B;
        b10.in_valid   = 1'b1;
        n = 0;
        while (!b10.in_ready && n < 40) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        b10.ciphertext = CT_C1;
        lat = 0;
        while (!b10.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        n_vec++; if (lat != 10 || b10.plaintext !== PT_B) begin n_err++; $display("FAIL b2b_first got lat=%0d %h want 10 %h", lat, b10.plaintext, PT_B); end
        expand({KEY_C1, 128'h0}, 4);
        @(posedge clk); #1;
        n_vec++; if (b10.out_valid !== 1'b0 || b10.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_gap got ov=%b rdy=%b want 0/1", b10.out_valid, b10.in_ready); end
        @(posedge clk); #1;
        n_vec++; if (b10.busy !== 1'b1 || b10.rk_idx !== 4'd9) begin n_err++; $display("FAIL b2b_second_accept got busy=%b rk=%0d want 1/9", b10.busy, b10.rk_idx); end
        b10.in_valid = 1'b0;
        lat = 0;
        while (!b10.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        n_vec++; if (lat != 10 || b10.plaintext !== PT_C) begin n_err++; $display("FAIL b2b_second got lat=%0d %h want 10 %h", lat, b10.plaintext, PT_C); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [127:0] pt;
        int n, lat;
        bit to, saw;
        expand({KEY_B, 128'h0}, 4);
        b10.out_ready  = 1'b1;
        b10.ciphertext = CT_B;
        b10.in_valid   = 1'b1;
        n = 0;
        while (!b10.in_ready && n < 40) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        b10.in_valid = 1'b0;
        n = 0;
        while (b10.rk_idx !== 4'd5 && n < 40) begin @(posedge clk); #1; n++; end
        n_vec++; if (b10.rk_idx !== 4'd5 || b10.busy !== 1'b1) begin n_err++; $display("FAIL mid_reach got rk=%0d busy=%b want 5/1", b10.rk_idx, b10.busy); end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (b10.busy !== 1'b0 || b10.out_valid !== 1'b0 || b10.plaintext !== 128'h0 || b10.rk_idx !== 4'd0) begin
            n_err++;
            $display("FAIL mid_async got busy=%b ov=%b rk=%0d pt=%h want 0/0/0 0", b10.busy, b10.out_valid, b10.rk_idx, b10.plaintext);
        end
        saw = 1'b0;
        repeat (2) begin @(posedge clk); #1; saw = saw || b10.out_valid; end
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (b10.in_ready !== 1'b1 || b10.busy !== 1'b0) begin n_err++; $display("FAIL mid_idle got rdy=%b busy=%b want 1/0", b10.in_ready, b10.busy); end
        repeat (14) begin @(posedge clk); #1; saw = saw || b10.out_valid; end
        n_vec++; if (saw) begin n_err++; $display("FAIL mid_no_output got out_valid pulse want none"); end
        run10(CT_B, pt, lat, to);
        n_vec++; if (to || lat != 10 || pt !== PT_B) begin n_err++; $display("FAIL mid_rerun got to=%b lat=%0d %h want 0 10 %h", to, lat, pt, PT_B); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [127:0] key, ct, exp, pt;
        int lat;
        bit to;
        for (int it = 0; it < 6; it++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            ct  = {$urandom, $urandom, $urandom, $urandom};
            expand({key, 128'h0}, 4);
            exp = ref_dec(ct, 10);
            b10.out_ready = 1'b0;
            run10(ct, pt, lat, to);
            n_vec++; if (to || lat != 10 || pt !== exp) begin n_err++; $display("FAIL rand%0d got to=%b lat=%0d %h want 0 10 %h", it, to, lat, pt, exp); end
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            n_vec++; if (b10.out_valid !== 1'b1 || b10.plaintext !== exp) begin n_err++; $display("FAIL rand%0d_hold got ov=%b %h want 1 %h", it, b10.out_valid, b10.plaintext, exp); end
            b10.out_ready = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_nr14();
        logic [255:0] key;
        logic [127:0] ct, exp;
        int n, lat;
        for (int it = 0; it < 2; it++) begin
            key = (it == 0) ? KEY_C3 : {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            ct  = (it == 0) ? CT_C3 : {$urandom, $urandom, $urandom, $urandom};
            expand(key, 8);
            exp = (it == 0) ? PT_C : ref_dec(ct, 14);
            b14.out_ready  = 1'b1;
            b14.ciphertext = ct;
            b14.in_valid   = 1'b1;
            n = 0;
            while (!b14.in_ready && n < 40) begin @(posedge clk); #1; n++; end
            n_vec++; if (b14.in_ready !== 1'b1 || b14.rk_idx !== 4'd14) begin n_err++; $display("FAIL nr14_%0d_idle got rdy=%b rk=%0d want 1/14", it, b14.in_ready, b14.rk_idx); end
            @(posedge clk); #1;
            b14.in_valid = 1'b0;
            lat = 0;
            while (!b14.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
            n_vec++; if (lat != 14 || b14.plaintext !== exp) begin n_err++; $display("FAIL nr14_%0d got lat=%0d %h want 14 %h", it, lat, b14.plaintext, exp); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        b10.in_valid = 1'b0; b10.out_ready = 1'b1; b10.ciphertext = '0;
        b14.in_valid = 1'b0; b14.out_ready = 1'b1; b14.ciphertext = '0;
        build_sbox();
        test_reset();
        test_fips_b();
        test_fips_c1();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_nr14();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
